pll_rst_seq: RTL

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

---
 rtl/pll_rst_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_rst_seq.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// Defining PLL_RST_SEQ_TIMEOUT_EN in the build enables the lock-timeout PLL reset path.
package pll_rst_pkg;

    localparam int unsigned CNT_W      = 20;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelSys   = 3'd3,
        StRun      = 3'd4,
        StPllRst   = 3'd5
    } seq_state_e;

    // Zero means one; anything beyond the counter range clamps to its maximum.
    function automatic logic [CNT_W-1:0] cyc_param(input int unsigned cyc);
        if (cyc == 0) begin
            return CNT_W'(1);
        end
        if (cyc > (32'd1 << CNT_W) - 32'd1) begin
            return '1;
        end
        return CNT_W'(cyc);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for quasi-static or level signals.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q, meta_d;
    logic [Width-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// Staged reset release after PLL lock, with lock-loss filtering and event counting.
// Build macro PLL_RST_SEQ_TIMEOUT_EN adds a PLL reset pulse when lock never arrives.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYC   = 1024,
    parameter int unsigned STAGE_GAP_CYC     = 256,
    parameter int unsigned LOSS_FILT_CYC     = 4,
    parameter int unsigned LOCK_TIMEOUT_CYC  = 500000,
    parameter int unsigned PLL_RST_PULSE_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    output logic                  sys_rst_n,
    output logic                  vid_rst_n,
    output logic                  pll_rst_req,
    output logic [LOCK_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            seq_state
);

    localparam logic [CNT_W-1:0] LockStable  = cyc_param(LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] GapLast     = cyc_param(STAGE_GAP_CYC) - 1'b1;
    localparam logic [CNT_W-1:0] FiltLast    = cyc_param(LOSS_FILT_CYC) - 1'b1;
    localparam logic [CNT_W-1:0] LockTimeout = cyc_param(LOCK_TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] PulseLast   = cyc_param(PLL_RST_PULSE_CYC) - 1'b1;

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic                  lock_s;
    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      filt_q, filt_d;
    logic [LOCK_CNT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic                  sys_rst_n_q, sys_rst_n_d;
    logic                  vid_rst_n_q, vid_rst_n_d;
    logic                  loss_event;
    logic                  cnt_en;

    sync_2ff #(
        .Width (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            filt_q      <= '0;
            loss_cnt_q  <= '0;
            sys_rst_n_q <= 1'b0;
            vid_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_q      <= filt_d;
            loss_cnt_q  <= loss_cnt_d;
            sys_rst_n_q <= sys_rst_n_d;
            vid_rst_n_q <= vid_rst_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        filt_d     = '0;
        loss_cnt_d = loss_cnt_q;
        loss_event = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            StIdle: state_d = StWaitLock;
            StWaitLock: begin
                cnt_en = TimeoutEn;
                if (lock_s) begin
                    state_d = StStable;
                end else if (TimeoutEn && (cnt_q == LockTimeout)) begin
                    state_d = StPllRst;
                end
            end
            StStable: begin
                cnt_en = 1'b1;
                if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == LockStable) begin
                    state_d = StRelSys;
                end
            end
            StRelSys, StRun: begin
                cnt_en = (state_q == StRelSys);
                // Only a run of FiltLast+1 low samples is a real loss; any high sample restarts it.
                if (!lock_s) begin
                    if (filt_q == FiltLast) begin
                        loss_event = 1'b1;
                    end else begin
                        filt_d = filt_q + 1'b1;
                    end
                end
                if (loss_event) begin
                    state_d = StWaitLock;
                end else if ((state_q == StRelSys) && (cnt_q == GapLast)) begin
                    state_d = StRun;
                end
            end
            StPllRst: begin
                cnt_en = 1'b1;
                if (cnt_q == PulseLast) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d  = '0;
            filt_d = '0;
        end else if (cnt_en && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (loss_event && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    // Both releases derive from the same registered state, so vid can never lead sys.
    always_comb begin
        sys_rst_n_d = (state_q == StRelSys) || (state_q == StRun);
        vid_rst_n_d = (state_q == StRun);
    end

`ifdef PLL_RST_SEQ_TIMEOUT_EN
    logic pll_rst_req_q, pll_rst_req_d;

    always_comb begin
        pll_rst_req_d = (state_q == StPllRst);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_rst_req_q <= 1'b0;
        end else begin
            pll_rst_req_q <= pll_rst_req_d;
        end
    end

    assign pll_rst_req = pll_rst_req_q;
`else
    assign pll_rst_req = 1'b0;
`endif

    assign sys_rst_n     = sys_rst_n_q;
    assign vid_rst_n     = vid_rst_n_q;
    assign lock_loss_cnt = loss_cnt_q;
    assign seq_state     = state_q;

endmodule
